// File: rtl/redux_pkg.sv
// Shared defaults and encodings for the fetch front end: bus widths, reset
// address, opcode field position and the fetch FSM state enum.
package redux_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 8;
  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 8'h00;

  // Opcode is the top nibble of the instruction word.
  localparam int OPCODE_W  = 4;
  localparam int OPCODE_HI = INSTR_W_DEF - 1;
  localparam int OPCODE_LO = INSTR_W_DEF - OPCODE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load has priority over increment, wraps modulo 2^PC_W,
// asynchronously returns to RESET_PC.
module pc_counter
  import redux_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one memory read at a time, holds the returned word
// for decode under a valid/ready handshake, and honours branch redirects.
module instruction_fetch
  import redux_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  fetch_state_e       state_q, state_d;
  logic               kill_q, kill_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [PC_W-1:0]    pc;
  logic               pc_inc;

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect),
    .load_val (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          // A redirect or a pending kill turns this ack into a discard.
          if (redirect || kill_q) begin
            kill_d = 1'b0;
          end else begin
            instr_d    = imem_data;
            instr_pc_d = pc;
            pc_inc     = 1'b1;
            state_d    = ST_HOLD;
          end
        end else if (redirect) begin
          // The in-flight read targets the old address; drop its ack.
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else if (instr_ready) begin
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: OPCODE_W];
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: walks the fetch FSM through a scripted
// sequence with hand-computed expected outputs after every clock edge.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [3:0] opcode;
  logic [7:0] instr_pc;
  logic       redirect;
  logic [7:0] redirect_pc;

  int vecs = 0;
  int errs = 0;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    step(); step();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", imem_req); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 8'h00) begin errs++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
    vecs++; if (instr !== 8'h00) begin errs++; $display("FAIL rst_instr: got %h want 00", instr); end
    vecs++; if (opcode !== 4'h0) begin errs++; $display("FAIL rst_opcode: got %h want 0", opcode); end
    vecs++; if (instr_pc !== 8'h00) begin errs++; $display("FAIL rst_instr_pc: got %h want 00", instr_pc); end
    rst = 1'b0;
    step();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL idle_no_run_req: got %b want 0", imem_req); end
  endtask

  task automatic test_basic_fetch();
    run = 1'b1;
    step();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL fetch_req: got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 8'h00) begin errs++; $display("FAIL fetch_addr: got %h want 00", imem_addr); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL fetch_valid: got %b want 0", instr_valid); end
    imem_ack = 1'b1; imem_data = 8'h41;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
    vecs++; if (instr !== 8'h41) begin errs++; $display("FAIL basic_instr: got %h want 41", instr); end
    vecs++; if (opcode !== 4'h4) begin errs++; $display("FAIL basic_opcode: got %h want 4", opcode); end
    vecs++; if (instr_pc !== 8'h00) begin errs++; $display("FAIL basic_instr_pc: got %h want 00", instr_pc); end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL basic_req: got %b want 0", imem_req); end
  endtask

  task automatic test_hold_stall();
    // Stray acks while holding must not disturb the register.
    imem_ack = 1'b1; imem_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++; if (instr !== 8'h41) begin errs++; $display("FAIL stall_instr[%0d]: got %h want 41", i, instr); end
      vecs++; if (instr_pc !== 8'h00) begin errs++; $display("FAIL stall_instr_pc[%0d]: got %h want 00", i, instr_pc); end
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
      vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL xfer_valid: got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 8'h01) begin errs++; $display("FAIL xfer_next_addr: got %h want 01", imem_addr); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL xfer_req: got %b want 1", imem_req); end
  endtask

  task automatic test_back_to_back();
    imem_ack = 1'b1; imem_data = 8'h52;
    step();
    vecs++; if (instr !== 8'h52) begin errs++; $display("FAIL b2b_instr0: got %h want 52", instr); end
    vecs++; if (instr_pc !== 8'h01) begin errs++; $display("FAIL b2b_pc0: got %h want 01", instr_pc); end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    vecs++; if (imem_addr !== 8'h02) begin errs++; $display("FAIL b2b_addr1: got %h want 02", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'h63; instr_ready = 1'b0;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr !== 8'h63) begin errs++; $display("FAIL b2b_instr1: got %h want 63", instr); end
    vecs++; if (instr_pc !== 8'h02) begin errs++; $display("FAIL b2b_pc1: got %h want 02", instr_pc); end
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid1: got %b want 1", instr_valid); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL redir_hold_valid: got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 8'hFF) begin errs++; $display("FAIL redir_hold_addr: got %h want ff", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'hA7;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr !== 8'hA7) begin errs++; $display("FAIL wrap_instr: got %h want a7", instr); end
    vecs++; if (opcode !== 4'hA) begin errs++; $display("FAIL wrap_opcode: got %h want a", opcode); end
    vecs++; if (instr_pc !== 8'hFF) begin errs++; $display("FAIL wrap_instr_pc: got %h want ff", instr_pc); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vecs++; if (imem_addr !== 8'h00) begin errs++; $display("FAIL wrap_addr: got %h want 00", imem_addr); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL wrap_req: got %b want 1", imem_req); end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b1; imem_data = 8'hBB; redirect = 1'b1; redirect_pc = 8'h20;
    step();
    imem_ack = 1'b0; redirect = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rack_valid: got %b want 0", instr_valid); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rack_req: got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 8'h20) begin errs++; $display("FAIL rack_addr: got %h want 20", imem_addr); end
    step();
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rack_valid2: got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 8'h20) begin errs++; $display("FAIL rack_addr2: got %h want 20", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'hC4;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr !== 8'hC4) begin errs++; $display("FAIL rack_instr: got %h want c4", instr); end
    vecs++; if (instr_pc !== 8'h20) begin errs++; $display("FAIL rack_instr_pc: got %h want 20", instr_pc); end
  endtask

  task automatic test_redirect_hold();
    redirect = 1'b1; redirect_pc = 8'h30; instr_ready = 1'b1;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rhold_valid: got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 8'h30) begin errs++; $display("FAIL rhold_addr: got %h want 30", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'hD5;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr !== 8'hD5) begin errs++; $display("FAIL rhold_instr: got %h want d5", instr); end
    vecs++; if (instr_pc !== 8'h30) begin errs++; $display("FAIL rhold_instr_pc: got %h want 30", instr_pc); end
  endtask

  task automatic test_kill();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vecs++; if (imem_addr !== 8'h31) begin errs++; $display("FAIL kill_pre_addr: got %h want 31", imem_addr); end
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL kill_req: got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 8'h40) begin errs++; $display("FAIL kill_addr: got %h want 40", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'h99;
    step();
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL kill_drop_valid: got %b want 0", instr_valid); end
    vecs++; if (imem_addr !== 8'h40) begin errs++; $display("FAIL kill_drop_addr: got %h want 40", imem_addr); end
    imem_data = 8'hE6;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL kill_refetch_valid: got %b want 1", instr_valid); end
    vecs++; if (instr !== 8'hE6) begin errs++; $display("FAIL kill_refetch_instr: got %h want e6", instr); end
    vecs++; if (instr_pc !== 8'h40) begin errs++; $display("FAIL kill_refetch_pc: got %h want 40", instr_pc); end
  endtask

  task automatic test_run_stop();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0; run = 1'b0;
    step();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL stop_req_kept: got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 8'h41) begin errs++; $display("FAIL stop_addr: got %h want 41", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'h17;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr !== 8'h17) begin errs++; $display("FAIL stop_instr: got %h want 17", instr); end
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL stop_valid: got %b want 1", instr_valid); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL stop_idle_valid: got %b want 0", instr_valid); end
    step();
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL stop_idle_req: got %b want 0", imem_req); end
  endtask

  task automatic test_redirect_idle();
    redirect = 1'b1; redirect_pc = 8'h50;
    step();
    redirect = 1'b0;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL ridle_req: got %b want 0", imem_req); end
    run = 1'b1;
    step();
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL ridle_fetch_req: got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 8'h50) begin errs++; $display("FAIL ridle_addr: got %h want 50", imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; run = 1'b0;
    #1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL arst_req: got %b want 0", imem_req); end
    vecs++; if (imem_addr !== 8'h00) begin errs++; $display("FAIL arst_pc: got %h want 00", imem_addr); end
    step();
    rst = 1'b0;
    imem_ack = 1'b1; imem_data = 8'h88;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL late_ack_valid: got %b want 0", instr_valid); end
    vecs++; if (instr !== 8'h00) begin errs++; $display("FAIL late_ack_instr: got %h want 00", instr); end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL late_ack_req: got %b want 0", imem_req); end
    run = 1'b1;
    step();
    vecs++; if (imem_addr !== 8'h00) begin errs++; $display("FAIL post_rst_addr: got %h want 00", imem_addr); end
    imem_ack = 1'b1; imem_data = 8'h2A;
    step();
    imem_ack = 1'b0;
    vecs++; if (instr !== 8'h2A) begin errs++; $display("FAIL post_rst_instr: got %h want 2a", instr); end
    vecs++; if (instr_pc !== 8'h00) begin errs++; $display("FAIL post_rst_instr_pc: got %h want 00", instr_pc); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_back_to_back();
    test_wrap();
    test_redirect_ack();
    test_redirect_hold();
    test_kill();
    test_run_stop();
    test_redirect_idle();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
